// File: rtl/clk_mon_pkg.sv
// Shared definitions for the switching-clock monitor: state encoding,
// default counter width and the unsigned in-tolerance window compare.
package clk_mon_pkg;

   localparam int CNT_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } mon_state_e;

   // Lower bound clamps at zero so a small expected value cannot wrap.
   function automatic logic in_tol(input logic [31:0] val,
                                   input logic [31:0] exp_val,
                                   input logic [31:0] tol);
      logic [31:0] lo;
      lo = (exp_val > tol) ? (exp_val - tol) : 32'd0;
      return (val >= lo) && (val <= (exp_val + tol));
   endfunction

endpackage

// File: rtl/switch_clock_monitor_if.sv
// Fsw/Fsw_bar monitor bus: switching clocks and error clear in, measurements
// and status out. master = clock source / control side, slave = monitor.
interface switch_clock_monitor_if import clk_mon_pkg::*; #(
   parameter int CNT_W = CNT_W_DEF
);
   logic             Fsw;
   logic             Fsw_bar;
   logic             err_clr;
   logic [CNT_W-1:0] half_period;
   logic [CNT_W-1:0] phase;
   logic             meas_valid;
   logic             locked;
   logic             period_err;
   logic             phase_err;
   logic             stuck_err;

   modport master (
      output Fsw, Fsw_bar, err_clr,
      input  half_period, phase, meas_valid, locked, period_err, phase_err, stuck_err
   );

   modport slave (
      input  Fsw, Fsw_bar, err_clr,
      output half_period, phase, meas_valid, locked, period_err, phase_err, stuck_err
   );
endinterface

// File: rtl/toggle_detect.sv
// Registers one switching clock and flags either edge polarity.
// CLK_MON_SYNC_EN adds a 2-flop synchronizer ahead of the edge register.
module toggle_detect (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic tgl
);
   logic samp_s;

`ifdef CLK_MON_SYNC_EN
   localparam int PRIME = 4;
   logic [1:0] sync_r;

   // Two-stage synchronizer for a source on a foreign clock.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync_r <= 2'b00;
      end else begin
         sync_r <= {sync_r[0], d};
      end
   end
   assign samp_s = sync_r[1];
`else
   localparam int PRIME = 2;
   assign samp_s = d;
`endif

   logic             d_r;
   logic             d_prev_r;
   logic [PRIME-1:0] prime_r;

   // Edge register; prime_r masks the bogus edge from reset-zeroed flops.
   always_ff @(posedge clk) begin
      if (!reset) begin
         d_r      <= 1'b0;
         d_prev_r <= 1'b0;
         prime_r  <= '0;
      end else begin
         d_r      <= samp_s;
         d_prev_r <= d_r;
         prime_r  <= {prime_r[PRIME-2:0], 1'b1};
      end
   end

   assign tgl = prime_r[PRIME-1] & (d_r ^ d_prev_r);
endmodule

// File: rtl/switch_clock_monitor.sv
// Measures Fsw half-period and Fsw->Fsw_bar phase, tracks lock, raises sticky
// faults. Build option CLK_MON_SYNC_EN (in toggle_detect) adds input sync.
module switch_clock_monitor import clk_mon_pkg::*; #(
   parameter int HALF_PERIOD = 51,
   parameter int PHASE_DLY   = 6,
   parameter int TOL         = 1,
   parameter int LOCK_CNT    = 4,
   parameter int CNT_W       = CNT_W_DEF
) (
   input logic                  clk,
   input logic                  reset,
   switch_clock_monitor_if.slave mon
);
   localparam int               GC_W      = $clog2(LOCK_CNT + 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] STUCK_PRE = CNT_W'(2 * HALF_PERIOD - 1);
   localparam logic [GC_W-1:0]  LAST_GOOD = GC_W'(LOCK_CNT - 1);

   logic             tgl_f_s, tgl_b_s;
   logic [CNT_W-1:0] pc_r, ph_r, ph_val_s, half_period_r, phase_r;
   logic             armed_r, ph_ok_r;
   logic             meas_valid_r, locked_r, period_err_r, phase_err_r, stuck_err_r;
   mon_state_e       state_r, state_nxt_s;
   logic [GC_W-1:0]  good_cnt_r, good_cnt_nxt_s;
   logic             capture_s, stuck_s, period_ok_s, ph_cap_s, ph_in_tol_s;
   logic             miss_bar_s, cap_good_s, phase_err_set_s;

   toggle_detect u_tgl_fsw     (.clk(clk), .reset(reset), .d(mon.Fsw),     .tgl(tgl_f_s));
   toggle_detect u_tgl_fsw_bar (.clk(clk), .reset(reset), .d(mon.Fsw_bar), .tgl(tgl_b_s));

   // A coincident Fsw_bar edge pairs with the new Fsw edge at zero offset.
   always_comb begin
      capture_s       = tgl_f_s && (state_r != IDLE);
      stuck_s         = (pc_r == STUCK_PRE) && !tgl_f_s;
      period_ok_s     = in_tol(32'(pc_r), 32'(HALF_PERIOD), 32'(TOL));
      ph_cap_s        = tgl_b_s && (armed_r || tgl_f_s);
      ph_val_s        = tgl_f_s ? '0 : ph_r;
      ph_in_tol_s     = in_tol(32'(ph_val_s), 32'(PHASE_DLY), 32'(TOL));
      miss_bar_s      = tgl_f_s && armed_r && !tgl_b_s;
      cap_good_s      = period_ok_s && ph_ok_r;
      phase_err_set_s = (state_r != IDLE) && ((ph_cap_s && !ph_in_tol_s) || miss_bar_s);
   end

   // Lock tracking; the stuck timeout overrides everything.
   always_comb begin
      state_nxt_s    = state_r;
      good_cnt_nxt_s = good_cnt_r;
      case (state_r)
         IDLE: begin
            if (tgl_f_s) begin
               state_nxt_s    = ACQUIRE;
               good_cnt_nxt_s = '0;
            end else begin
               state_nxt_s    = IDLE;
            end
         end
         ACQUIRE: begin
            if (capture_s && cap_good_s && (good_cnt_r == LAST_GOOD)) begin
               state_nxt_s    = LOCKED;
               good_cnt_nxt_s = '0;
            end else if (capture_s && cap_good_s) begin
               good_cnt_nxt_s = good_cnt_r + GC_W'(1);
            end else if (capture_s) begin
               good_cnt_nxt_s = '0;
            end else begin
               good_cnt_nxt_s = good_cnt_r;
            end
         end
         LOCKED: begin
            if (capture_s && !cap_good_s) begin
               state_nxt_s    = ACQUIRE;
               good_cnt_nxt_s = '0;
            end else begin
               state_nxt_s    = LOCKED;
            end
         end
         default: begin
            state_nxt_s    = IDLE;
            good_cnt_nxt_s = '0;
         end
      endcase
      if (stuck_s) begin
         state_nxt_s    = IDLE;
         good_cnt_nxt_s = '0;
      end else begin
         good_cnt_nxt_s = good_cnt_nxt_s;
      end
   end

   // Counters, captures and state register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r       <= IDLE;
         good_cnt_r    <= '0;
         locked_r      <= 1'b0;
         pc_r          <= '0;
         ph_r          <= '0;
         armed_r       <= 1'b0;
         ph_ok_r       <= 1'b0;
         meas_valid_r  <= 1'b0;
         half_period_r <= '0;
         phase_r       <= '0;
      end else begin
         state_r      <= state_nxt_s;
         good_cnt_r   <= good_cnt_nxt_s;
         locked_r     <= (state_nxt_s == LOCKED);
         meas_valid_r <= capture_s;
         pc_r         <= tgl_f_s ? CNT_ONE : ((pc_r == CNT_MAX) ? pc_r : pc_r + CNT_ONE);
         if (capture_s) half_period_r <= pc_r;
         if (ph_cap_s) phase_r <= ph_val_s;
         if (tgl_f_s) begin
            ph_r    <= CNT_ONE;
            armed_r <= !tgl_b_s;
            ph_ok_r <= tgl_b_s && ph_in_tol_s;
         end else begin
            ph_r <= (ph_r == CNT_MAX) ? ph_r : ph_r + CNT_ONE;
            if (ph_cap_s) begin
               armed_r <= 1'b0;
               ph_ok_r <= ph_in_tol_s;
            end
         end
      end
   end

   // Sticky faults: a set condition beats a simultaneous err_clr.
   always_ff @(posedge clk) begin
      if (!reset) begin
         period_err_r <= 1'b0;
         phase_err_r  <= 1'b0;
         stuck_err_r  <= 1'b0;
      end else begin
         period_err_r <= (capture_s && !period_ok_s) | (period_err_r & ~mon.err_clr);
         phase_err_r  <= phase_err_set_s             | (phase_err_r  & ~mon.err_clr);
         stuck_err_r  <= stuck_s                     | (stuck_err_r  & ~mon.err_clr);
      end
   end

   assign mon.half_period = half_period_r;
   assign mon.phase       = phase_r;
   assign mon.meas_valid  = meas_valid_r;
   assign mon.locked      = locked_r;
   assign mon.period_err  = period_err_r;
   assign mon.phase_err   = phase_err_r;
   assign mon.stuck_err   = stuck_err_r;
endmodule

// File: doc/switch_clock_monitor.md
# switch_clock_monitor

Receive-side checker for the complementary switching clocks Fsw and Fsw_bar produced by the gate-drive clock source. It measures the Fsw half-period and the Fsw-to-Fsw_bar phase offset in clk cycles and compares both against expected values. It reports lock status and sticky faults to the converter control/protection logic, which gates the power stage on `locked` and trips on any error.

## Interface
Parameters:
- HALF_PERIOD, 51: expected clk cycles between consecutive Fsw toggles.
- PHASE_DLY, 6: expected clk cycles from an Fsw toggle to the following Fsw_bar toggle.
- TOL, 1: allowed ± deviation on both measurements.
- LOCK_CNT, 4: consecutive good half-periods required to lock.
- CNT_W, 8: measurement counter width; counters saturate at 2^CNT_W−1.

Ports:
- clk  in  1  single system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- Fsw  in  1  switching clock under test.
- Fsw_bar  in  1  delayed companion switching clock.
- err_clr  in  1  one-cycle pulse that clears all sticky errors.
- half_period  out  CNT_W  last captured Fsw toggle spacing; reset 0.
- phase  out  CNT_W  last captured Fsw→Fsw_bar offset; reset 0.
- meas_valid  out  1  one-cycle pulse when half_period is updated; reset 0.
- locked  out  1  1 while state is LOCKED; reset 0.
- period_err  out  1  sticky: half-period outside HALF_PERIOD±TOL; reset 0.
- phase_err  out  1  sticky: phase outside PHASE_DLY±TOL, or Fsw toggled twice with no Fsw_bar toggle between; reset 0.
- stuck_err  out  1  sticky: no Fsw toggle for 2·HALF_PERIOD cycles; reset 0.

## Operation
- Inputs are registered once; a toggle is detected when the registered value differs from its previous registered value. Both edge polarities count.
- Period counter `pc`:
  - Loads 1 on an Fsw toggle; otherwise increments, saturating.
  - On an Fsw toggle, the value of `pc` just before the load is captured into half_period.
  - The first toggle after reset or after leaving IDLE only restarts `pc`; nothing is captured.
- Phase counter `ph`:
  - Loads 1 on an Fsw toggle and is armed.
  - On a Fsw_bar toggle while armed, `ph` is captured into phase and the counter disarms.
  - A simultaneous Fsw and Fsw_bar toggle captures phase = 0.
  - If Fsw toggles while still armed, phase_err is set and `ph` re-arms.
- State machine:
  - IDLE → ACQUIRE on the first Fsw toggle.
  - ACQUIRE → LOCKED when LOCK_CNT consecutive captures pass both the period check and the phase check. The good-capture count resets to 0 on any failing capture.
  - LOCKED → ACQUIRE on any failing capture.
  - Any state → IDLE when `pc` reaches 2·HALF_PERIOD; stuck_err is set at the same time.
- Sticky errors set in every state except IDLE (stuck_err excepted). They clear only on reset or err_clr. If err_clr and a set condition occur in the same cycle, set wins.
- Comparison arithmetic is unsigned. A capture passes when HALF_PERIOD−TOL ≤ value ≤ HALF_PERIOD+TOL; the lower bound is clamped at 0.
- Reset mid-operation: the next cycle has all outputs at reset values, state IDLE, and counters 0.

## Timing
- Fsw toggle at input in cycle n is registered at n+1 and detected at n+1. half_period, meas_valid, and error flags update at the n+2 edge, giving 2-cycle latency.
- The phase capture path has the same 2-cycle latency.
- locked rises in the same cycle as the meas_valid of the LOCK_CNT-th good capture. It falls in the same cycle as the meas_valid of a failing capture.
- With CLK_MON_SYNC_EN defined, every latency above is +2 cycles.

## Configuration
- CLK_MON_SYNC_EN defined: Fsw and Fsw_bar each pass through a 2-flop synchronizer ahead of the edge register, for use when the source runs on another clock.
- CLK_MON_SYNC_EN undefined: inputs are taken as synchronous to clk, with a single register stage only.

## Structure
- Shared package clk_mon_pkg holds:
  - state enum IDLE/ACQUIRE/LOCKED;
  - default CNT_W;
  - the in-tolerance compare as a function.
- Sub-module toggle_detect (optional sync stages, register, XOR toggle output) is instantiated once for Fsw and once for Fsw_bar.

## Test plan
- Nominal source (Fsw toggles every 51 cycles, Fsw_bar 6 cycles later) → locked=1 on the 4th meas_valid; half_period=51, phase=6; no errors.
- Fsw toggle spacing changed to 54 after lock → period_err=1 and locked=0 on that capture; re-lock after 4 good captures; period_err stays 1 until err_clr.
- Fsw_bar held constant while Fsw toggles → phase_err=1 at the second Fsw toggle; locked never 1.
- Fsw frozen after lock → stuck_err=1 and state IDLE when pc=102; locked=0.
- reset=0 for one cycle mid-lock → all outputs 0 next cycle; 5 toggles needed to re-lock.
- err_clr pulsed in the same cycle as a new period violation → period_err remains 1.
